// File: rtl/odev_uart_tx_if.sv
// odev_uart_tx_if: write strobe/data from the odev0 decode plus serial line and FIFO status
interface odev_uart_tx_if #(parameter int CNT_W = 3);
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             tx;
  logic             busy;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  modport master (output wr_en, wr_data, input tx, busy, full, empty, fifo_count, overflow);
  modport slave  (input wr_en, wr_data, output tx, busy, full, empty, fifo_count, overflow);
endinterface

// File: rtl/odev_uart_tx.sv
// odev_uart_tx: FIFO-buffered 8N1 serial transmitter fed by CPU output device 0
module odev_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3
) (
  input logic clk,
  input logic rst,
  odev_uart_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t           state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic             tx_q, tx_d, busy_q, ovf_q;
  logic             full, empty, push, pop, tick;
  assign full  = cnt_q == CNT_W'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign push  = bus.wr_en && !full;
  assign tick  = baud_q == BW'(CLKS_PER_BIT - 1);
  assign cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.fifo_count = cnt_q;
  assign bus.overflow   = ovf_q;
  // Frame sequencing: pop on leaving IDLE or STOP, shift LSB first, tx/busy follow the next state
  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + BW'(1);
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        shift_d = mem_q[rptr_q];
        state_d = START;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (tick) begin
        pop     = !empty;
        shift_d = empty ? shift_q : mem_q[rptr_q];
        state_d = empty ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
  end
  // Control and datapath registers; reset abandons any partial frame and empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= push ? wptr_q + AW'(1) : wptr_q;
      rptr_q  <= pop ? rptr_q + AW'(1) : rptr_q;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
      busy_q  <= state_d != IDLE;
      ovf_q   <= ovf_q | (bus.wr_en & full);
    end
  end
  // FIFO storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.wr_data;
  end
endmodule

// File: doc/odev_uart_tx.md
Name: odev_uart_tx

Overview:
- Serial transmitter that consumes bytes the CPU writes to output device 0 and shifts them out as 8N1 asynchronous serial frames.
- Sits directly downstream of the CPU's odev0 port.
- The top level generates `wr_en` as a one-cycle strobe from the odev0 load-enable term, active when the CPU writes RAM with address bit 0 low in the device page. `wr_data` is the data bus value in that cycle.
- A small FIFO decouples CPU writes from the slow serial line, so short bursts of OUT instructions do not stall or get lost.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range ≥2.
- FIFO_DEPTH, 4, byte entries; power of two, ≥2.
- CNT_W, 3, width of `fifo_count`; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  one-cycle write strobe from the odev0 decode.
- wr_data  input  8  byte to transmit; sampled when `wr_en`=1.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress (START, DATA or STOP state).
- full  output  1  FIFO holds FIFO_DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- fifo_count  output  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky; set when a write is dropped because the FIFO is full.

Behaviour:
- Reset (async, any time, including mid-frame):
  - `tx`=1, `busy`=0, `full`=0, `empty`=1, `fifo_count`=0, `overflow`=0.
  - FIFO pointers, bit counter, baud counter and shift register cleared.
  - FSM goes to IDLE; any partial frame is abandoned.
- FIFO:
  - Synchronous write on `wr_en` when not full.
  - If `wr_en`=1 while full, the byte is discarded and `overflow` is set. `overflow` is cleared only by `rst`.
  - The FSM pops the FIFO when it leaves IDLE or STOP with data available.
  - Simultaneous push and pop while full: the pop happens at that edge but the push is still judged against the pre-edge `full`, so the byte is dropped and `overflow` is set.
  - Simultaneous push and pop when not full: both take effect and `fifo_count` is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If `empty`=0 at an edge, pop the head into the shift register, clear the baud counter and go to START. A byte pushed into an empty FIFO at edge N is popped at edge N+1, so `tx` falls after edge N+1.
  - START: `tx`=0 for exactly CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. After each bit, shift right and increment the index. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles.
    - At the end of STOP, if `empty`=0, pop and go directly to START (no idle gap between frames).
    - Otherwise go to IDLE.
- Frame length is exactly 10×CLKS_PER_BIT cycles.
- `tx` is driven from a register (no glitches). `busy` is registered and is 1 in START, DATA and STOP.
- The baud counter counts 0..CLKS_PER_BIT-1 and advances the bit on the terminal count.
- Bytes written while a frame is in progress are queued and never corrupt the shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset then idle: assert `rst` for 3 cycles, release, wait 20 cycles → `tx`=1, `busy`=0, `empty`=1, `fifo_count`=0, `overflow`=0 throughout.
- Single byte: pulse `wr_en` with 0xA5 at edge N.
  - `tx` goes low after edge N+1 for 4 cycles.
  - Then data bits 1,0,1,0,0,1,0,1 at 4 cycles each.
  - Then high for 4 cycles.
  - `busy` is high for exactly 40 cycles, then IDLE.
- Back-to-back: write 0x01, 0x02, 0x03 on consecutive cycles.
  - `fifo_count` peaks at 2 (first byte popped at the next edge).
  - Three frames of 40 cycles each with no idle gap; START of frame 2 begins the cycle after STOP of frame 1.
- Overflow: write 6 bytes 0x10..0x15 on consecutive cycles.
  - 0x10 is popped one edge after being written; then 0x11..0x14 fill the FIFO, so `full`=1 and `fifo_count`=4.
  - 0x15 is dropped and `overflow`=1.
  - Serial output is 0x10, 0x11, 0x12, 0x13, 0x14, in that order.
- Reset mid-frame: write 0xFF and 0x00, then assert `rst` during DATA bit 3.
  - `tx`=1 immediately (async), `fifo_count`=0.
  - After release no frame is emitted.
  - A new write of 0x3C is then sent correctly.
- Simultaneous push/pop: hold the FIFO at count 1 during STOP of a frame and write a byte on the edge the FSM pops → `fifo_count` remains 1 and no byte is lost.
